// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU datapath control bundle for alu_sequencer.
// Valid/ready: an instruction transfers on a rising edge where instr_valid and instr_ready are both high.
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_op;
    logic        instr_chain;
    logic [15:0] instr_a;
    logic [15:0] instr_b;
    logic [15:0] alu_result;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        a_enable;
    logic        acc_enable;
    logic        addsub;
    logic        xor_ctrl;
    logic        done;
    logic        err;
    logic [7:0]  op_count;

    modport slave (
        input  instr_valid, instr_op, instr_chain, instr_a, instr_b, alu_result,
        output instr_ready, a_data, b_data, a_enable, acc_enable, addsub,
        xor_ctrl, done, err, op_count
    );

    modport master (
        output instr_valid, instr_op, instr_chain, instr_a, instr_b, alu_result,
        input  instr_ready, a_data, b_data, a_enable, acc_enable, addsub,
        xor_ctrl, done, err, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state sequencer that steps an external ALU through load-A, execute and
// completion for ADD/SUB/XOR instructions, counting completed legal operations.
module alu_sequencer (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus,
    output logic [1:0]      fsm_state
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic        chain_q;
    logic [15:0] a_q, b_q;
    logic [15:0] a_hold, b_hold;
    logic [7:0]  count_q;
    logic        illegal;
    logic        accept;
    logic [15:0] a_sel;

    logic        ready;
    logic [15:0] a_data, b_data;
    logic        a_enable, acc_enable, addsub, xor_ctrl, done, err;

    assign illegal = (op_q == OP_ILL);
    assign accept  = bus.instr_valid && ready;
    // Chained operand comes straight from the accumulator while in LOAD_A.
    assign a_sel   = chain_q ? bus.alu_result : a_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            chain_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_hold  <= '0;
            b_hold  <= '0;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= bus.instr_op;
                chain_q <= bus.instr_chain;
                a_q     <= bus.instr_a;
                b_q     <= bus.instr_b;
            end
            if (state == LOAD_A) a_hold <= a_sel;
            if (state == EXEC)   b_hold <= b_q;
            if (state == DONE && !illegal) count_q <= count_q + 8'd1;
        end
    end

    // Every strobe is gated by rst so nothing fires while reset is held.
    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        a_data     = a_hold;
        b_data     = b_hold;
        a_enable   = 1'b0;
        acc_enable = 1'b0;
        addsub     = 1'b0;
        xor_ctrl   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                ready = !rst;
                if (accept) state_nxt = LOAD_A;
            end
            LOAD_A: begin
                a_enable  = !rst;
                a_data    = a_sel;
                state_nxt = EXEC;
            end
            EXEC: begin
                b_data     = b_q;
                acc_enable = !rst && !illegal;
                addsub     = !rst && (op_q == OP_SUB);
                xor_ctrl   = !rst && (op_q == OP_XOR);
                state_nxt  = DONE;
            end
            DONE: begin
                done      = !rst;
                err       = !rst && illegal;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.instr_ready = ready;
    assign bus.a_data      = a_data;
    assign bus.b_data      = b_data;
    assign bus.a_enable    = a_enable;
    assign bus.acc_enable  = acc_enable;
    assign bus.addsub      = addsub;
    assign bus.xor_ctrl    = xor_ctrl;
    assign bus.done        = done;
    assign bus.err         = err;
    assign bus.op_count    = count_q;
    assign fsm_state       = state;

    logic unused_ok;
    assign unused_ok = (OP_ADD == 2'b00);
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed instructions against a behavioural ALU,
// with a done-driven monitor popping expected results from a queue.
module tb_alu_sequencer;
    localparam int W = 57;  // {err, result[15:0], op_count_after[7:0], accept_cycle[31:0]}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fsm_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Behavioural ALU: A register, then accumulator with add/sub/xor paths.
    logic [15:0] a_reg = 16'h0;
    logic [15:0] acc   = 16'h0;
    assign bus.alu_result = acc;
    always @(posedge clk) begin
        if (bus.a_enable) a_reg <= bus.a_data;
        if (bus.acc_enable)
            acc <= bus.xor_ctrl ? (a_reg ^ bus.b_data)
                                : (a_reg + (bus.addsub ? ~bus.b_data : bus.b_data) + {15'd0, bus.addsub});
    end

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: result/err/latency on done, op_count one cycle later.
    logic       cnt_pend = 1'b0;
    logic [7:0] cnt_exp  = 8'h0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (cnt_pend) begin
            check("op_count_after_done", 32'(bus.op_count), 32'(cnt_exp));
            cnt_pend = 1'b0;
        end
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("err", 32'(bus.err), 32'(e[56]));
                check("result", 32'(bus.alu_result), 32'(e[55:40]));
                check("latency", 32'(cyc) - e[31:0], 32'd3);
                cnt_exp  = e[39:32];
                cnt_pend = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.instr_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_strobes", 32'({bus.a_enable, bus.acc_enable, bus.addsub, bus.xor_ctrl, bus.done, bus.err}), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_a_data", 32'(bus.a_data), 32'd0);
        check("rst_b_data", 32'(bus.b_data), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.instr_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic chain, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_a,
                         input logic [15:0] exp_res, input logic [7:0] exp_cnt);
        logic err_e;
        err_e = (op == 2'b11);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_chain = chain;
        bus.instr_a     = a;
        bus.instr_b     = b;
        wait_ready();
        exp_q.push_back({err_e, exp_res, exp_cnt, 32'(cyc)});
        @(posedge clk);
        #1;
        // Scrambled inputs after acceptance must not disturb the operation.
        bus.instr_valid = 1'b0;
        bus.instr_op    = ~op;
        bus.instr_chain = ~chain;
        bus.instr_a     = ~a;
        bus.instr_b     = ~b;
        @(negedge clk);
        check("load_a_enable", 32'(bus.a_enable), 32'd1);
        check("load_a_data", 32'(bus.a_data), 32'(exp_a));
        check("load_acc_enable", 32'(bus.acc_enable), 32'd0);
        check("load_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        check("exec_acc_enable", 32'(bus.acc_enable), 32'(!err_e));
        check("exec_addsub", 32'(bus.addsub), 32'(op == 2'b01));
        check("exec_xor_ctrl", 32'(bus.xor_ctrl), 32'(op == 2'b10));
        check("exec_b_data", 32'(bus.b_data), 32'(b));
        check("exec_a_enable", 32'(bus.a_enable), 32'd0);
        check("exec_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int last_cyc;
        int n;
        bus.instr_valid = 1'b0;
        bus.instr_op    = 2'b00;
        bus.instr_chain = 1'b0;
        bus.instr_a     = 16'h0;
        bus.instr_b     = 16'h0;

        do_reset();
        issue(2'b00, 1'b0, 16'h0003, 16'h0004, 16'h0003, 16'h0007, 8'd1);
        issue(2'b01, 1'b0, 16'h0005, 16'h0007, 16'h0005, 16'hFFFE, 8'd2);
        repeat (3) @(negedge clk);

        do_reset();
        issue(2'b10, 1'b0, 16'hF0F0, 16'hFF00, 16'hF0F0, 16'h0FF0, 8'd1);
        issue(2'b00, 1'b1, 16'hDEAD, 16'h0001, 16'h0FF0, 16'h0FF1, 8'd2);
        issue(2'b11, 1'b0, 16'h1234, 16'h5678, 16'h1234, 16'h0FF1, 8'd2);
        repeat (3) @(negedge clk);

        // Reset during EXEC aborts the instruction.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 2'b00;
        bus.instr_chain = 1'b0;
        bus.instr_a     = 16'h0001;
        bus.instr_b     = 16'h0001;
        wait_ready();
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_exec", 32'(fsm_state), 32'd2);
        rst = 1'b1;
        #1;
        check("abort_rst_strobes", 32'({bus.acc_enable, bus.addsub, bus.xor_ctrl, bus.instr_ready}), 32'd0);
        @(negedge clk);
        check("abort_state_idle", 32'(fsm_state), 32'd0);
        check("abort_no_done", 32'(bus.done), 32'd0);
        check("abort_a_enable", 32'(bus.a_enable), 32'd0);
        check("abort_ready_in_rst", 32'(bus.instr_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(bus.instr_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("abort_op_count", 32'(bus.op_count), 32'd0);

        // 256 back-to-back ADDs with instr_valid held high.
        last_cyc = 0;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_ready();
            if (i > 0) check("b2b_ready_gap", 32'(cyc - last_cyc), 32'd4);
            last_cyc        = cyc;
            bus.instr_op    = 2'b00;
            bus.instr_chain = 1'b0;
            bus.instr_a     = 16'(i);
            bus.instr_b     = 16'h0100;
            exp_q.push_back({1'b0, 16'(i + 256), 8'(i + 1), 32'(cyc)});
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("op_count_wrapped", 32'(bus.op_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
